ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries (fixed at 2 in this release).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rom_ce_o  output  1  fetch request strobe to instruction ROM.
REQ-006 rom_addr_o  output  32  byte address of requested word.
REQ-007 rom_inst_i  input  32  ROM read data, valid one cycle after rom_ce_o.
REQ-008 jump_en_i  input  1  redirect from execute stage.
REQ-009 jump_addr_i  input  32  redirect target.
REQ-010 hold_i  input  1  downstream stall; instruction not consumed.
REQ-011 inst_valid_o  output  1  inst_o/inst_addr_o hold a real instruction.
REQ-012 inst_o  output  32  instruction to decode stage.
REQ-013 inst_addr_o  output  32  address of inst_o.

Function
REQ-014 pc_q holds the next fetch address; rom_addr_o SHALL equal pc_q combinationally.
REQ-015 Issue condition: rst_n high, jump_en_i low, (occupancy after this cycle's pop + in-flight count) < DEPTH; rom_ce_o SHALL equal the issue condition.
REQ-016 On issue, pc_q SHALL advance by 4, 32-bit modulo (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 At most one request in flight; its address SHALL be captured at issue and paired with its returning data.
REQ-018 Returning data SHALL be written to the buffer at the end of the cycle after issue; first valid output appears two cycles after issue (latency 2).
REQ-019 inst_valid_o SHALL equal buffer-not-empty; inst_o/inst_addr_o SHALL show the buffer head.
REQ-020 When inst_valid_o is low, inst_o SHALL be 32'h0000_0013 (NOP) and inst_addr_o SHALL be 0.
REQ-021 Pop SHALL occur when inst_valid_o high and hold_i low; held head SHALL remain stable.
REQ-022 Sustained throughput SHALL be one instruction per cycle with hold_i low.
REQ-023 Write and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-024 jump_en_i high: buffer flushed, in-flight response discarded, pc_q loaded with {jump_addr_i[31:2],2'b00}, no issue that cycle; fetch of target issued next cycle.
REQ-025 jump_en_i overrides hold_i and any simultaneous write; inst_valid_o SHALL be low the cycle after a jump.
REQ-026 Buffer full (occupancy DEPTH) SHALL block issue; never overflow, never drop an instruction.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear buffer, in-flight flag, and set pc_q to RESET_PC, mid-operation included.
REQ-028 During reset: rom_ce_o 0, rom_addr_o RESET_PC, inst_valid_o 0, inst_o NOP, inst_addr_o 0.
REQ-029 First issue SHALL occur in the first cycle with rst_n sampled high.

Structure
REQ-030 Shared package SHALL hold NOP encoding 32'h0000_0013, RESET_PC default, DEPTH default, XLEN=32.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (entries {addr,inst}, flush input, simultaneous push/pop).

Verification
REQ-032 Reset release, ROM[i]=i+1, hold low -> rom_addr 0,4,8 on consecutive cycles; inst_valid two cycles after first issue; inst_o 1,2,3 with addr 0,4,8 back-to-back.
REQ-033 hold_i high 5 cycles at addr 8 -> inst_o stays 3/addr 8, rom_ce_o low once buffer+in-flight=2, resume yields addr 12 next with no gap or duplicate.
REQ-034 jump_en_i with target 32'h0000_0103 while buffer full and hold high -> next cycle inst_valid 0, inst_o NOP; rom_addr 32'h100; first valid inst_addr 32'h100 two cycles later.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst_n low mid-stream with buffer non-empty -> outputs take reset values asynchronously; after release fetch restarts at RESET_PC, no stale instruction emitted.
REQ-037 Full RV32UI program in SoC with x26/x27 end-of-test convention -> x27==1 when x26 reaches 1.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package ifu_prefetch_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          DEPTH_DEF    = 2;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ROM request/response and decode-side signals of the prefetch unit.
interface ifu_prefetch_if;
  logic                              rom_ce_o;
  logic [ifu_prefetch_pkg::XLEN-1:0] rom_addr_o;
  logic [ifu_prefetch_pkg::XLEN-1:0] rom_inst_i;
  logic                              jump_en_i;
  logic [ifu_prefetch_pkg::XLEN-1:0] jump_addr_i;
  logic                              hold_i;
  logic                              inst_valid_o;
  logic [ifu_prefetch_pkg::XLEN-1:0] inst_o;
  logic [ifu_prefetch_pkg::XLEN-1:0] inst_addr_o;

  modport master (
    output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  rom_inst_i, jump_en_i, jump_addr_i, hold_i
  );
  modport slave (
    input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output rom_inst_i, jump_en_i, jump_addr_i, hold_i
  );
endinterface

// File: rtl/ifu_prefetch_fifo.sv
// Small prefetch buffer of {addr,inst} entries; push and pop may coincide, flush empties it.
module fetch_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] occ
);
  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != CW'(DEPTH)) | do_pop);
  assign empty   = (cnt == '0);
  assign occ     = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: cnt alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: one outstanding ROM read, latency 2, small buffer toward decode.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  ifu_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, infl_addr_q;
  logic            infl_q;
  logic [CW-1:0]   occ;
  logic            empty, pop, push, issue;
  logic [CW:0]     occ_next;
  fetch_entry_t    head, wdata;

  assign pop   = ~empty & ~bus.hold_i;
  // A redirect discards the response that returns this cycle.
  assign push  = infl_q & ~bus.jump_en_i;
  assign wdata = '{addr: infl_addr_q, inst: bus.rom_inst_i};

  // Occupancy once this cycle's pop and returning data settle; a new request
  // is only allowed if its data is guaranteed a slot.
  assign occ_next = {1'b0, occ} - (CW+1)'(pop) + (CW+1)'(infl_q);
  assign issue    = rst_n & ~bus.jump_en_i & (occ_next < (CW+1)'(DEPTH));

  assign bus.rom_ce_o     = issue;
  assign bus.rom_addr_o   = pc_q;
  assign bus.inst_valid_o = ~empty;
  assign bus.inst_o       = empty ? NOP_INST : head.inst;
  assign bus.inst_addr_o  = empty ? '0 : head.addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
    end else if (bus.jump_en_i) begin
      pc_q   <= bus.jump_addr_i & ~32'h3;
      infl_q <= 1'b0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        pc_q        <= pc_q + 32'd4;
        infl_addr_q <= pc_q;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.jump_en_i),
    .push  (push),
    .din   (wdata),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .occ   (occ)
  );
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed table-driven bench for ifu_prefetch; ROM model returns addr/4+1.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  typedef struct {
    logic        rst_n, hold, jump;
    logic [31:0] jaddr;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst, iaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, hold = 1'b0, jump = 1'b0;
  logic [31:0] jaddr = '0;
  int          vecs = 0, errs = 0;
  vec_t        tbl1[$], tbl2[$];

  always #5 clk = ~clk;

  ifu_prefetch_if b1();
  ifu_prefetch_if b2();
  ifu_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  ifu_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b1.hold_i = hold;  assign b1.jump_en_i = jump;  assign b1.jump_addr_i = jaddr;
  assign b2.hold_i = hold;  assign b2.jump_en_i = jump;  assign b2.jump_addr_i = jaddr;

  // Synchronous ROM: data one cycle after the strobe, ROM[i] = i+1.
  always @(posedge clk) if (b1.rom_ce_o) b1.rom_inst_i <= (b1.rom_addr_o >> 2) + 32'd1;
  always @(posedge clk) if (b2.rom_ce_o) b2.rom_inst_i <= (b2.rom_addr_o >> 2) + 32'd1;

  function automatic vec_t mk(input logic r, h, j, input logic [31:0] ja,
                              input logic ce, input logic [31:0] a,
                              input logic v, input logic [31:0] i, ia);
    vec_t x;
    x.rst_n = r; x.hold = h; x.jump = j; x.jaddr = ja;
    x.ce = ce; x.addr = a; x.valid = v; x.inst = i; x.iaddr = ia;
    return x;
  endfunction

  task automatic run(input vec_t t[$], input bit hi, input string nm);
    logic        ce, v;
    logic [31:0] a, i, ia;
    for (int k = 0; k < t.size(); k++) begin
      @(negedge clk);
      rst_n = t[k].rst_n; hold = t[k].hold; jump = t[k].jump; jaddr = t[k].jaddr;
      #1;
      if (hi) begin ce = b2.rom_ce_o; a = b2.rom_addr_o; v = b2.inst_valid_o; i = b2.inst_o; ia = b2.inst_addr_o; end
      else    begin ce = b1.rom_ce_o; a = b1.rom_addr_o; v = b1.inst_valid_o; i = b1.inst_o; ia = b1.inst_addr_o; end
      vecs++;
      if (ce !== t[k].ce || a !== t[k].addr || v !== t[k].valid ||
          i !== t[k].inst || ia !== t[k].iaddr) begin
        errs++;
        $display("FAIL %s[%0d]: got ce=%0b addr=%h valid=%0b inst=%h iaddr=%h, want ce=%0b addr=%h valid=%0b inst=%h iaddr=%h",
                 nm, k, ce, a, v, i, ia, t[k].ce, t[k].addr, t[k].valid, t[k].inst, t[k].iaddr);
      end
    end
  endtask

  initial begin
    //                rst h j jaddr          ce addr           v inst           iaddr
    tbl1.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, NOP_INST,     32'h0));   // in reset
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0,         0, NOP_INST,     32'h0));   // first issue
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h4,         0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h8,         1, 32'h1,        32'h0));   // latency 2
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'hC,         1, 32'h2,        32'h4));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,        1, 32'h3,        32'h8));   // hold x5
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,        1, 32'h3,        32'h8));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,        1, 32'h3,        32'h8));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,        1, 32'h3,        32'h8));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h10,        1, 32'h3,        32'h8));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h10,        1, 32'h3,        32'h8));   // resume
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h14,        1, 32'h4,        32'hC));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h18,        1, 32'h5,        32'h10));  // fill
    tbl1.push_back(mk(1, 1, 1, 32'h103,      0, 32'h18,        1, 32'h5,        32'h10));  // jump, full+hold
    tbl1.push_back(mk(1, 1, 0, 32'h0,        1, 32'h100,       0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        1, 32'h104,       0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 1, 0, 32'h0,        0, 32'h108,       1, 32'h41,       32'h100));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h108,       1, 32'h41,       32'h100));
    tbl1.push_back(mk(1, 0, 1, 32'h200,      0, 32'h10C,       1, 32'h42,       32'h104)); // jump drops in-flight
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h200,       0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h204,       0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h208,       1, 32'h81,       32'h200));
    tbl1.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, NOP_INST,     32'h0));   // async reset mid-stream
    tbl1.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0,         0, NOP_INST,     32'h0));
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h4,         0, NOP_INST,     32'h0));   // no stale entry
    tbl1.push_back(mk(1, 0, 0, 32'h0,        1, 32'h8,         1, 32'h1,        32'h0));

    // Address wrap with a high reset PC.
    tbl2.push_back(mk(0, 0, 0, 32'h0,        0, 32'hFFFF_FFF8, 0, NOP_INST,     32'h0));
    tbl2.push_back(mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFF8, 0, NOP_INST,     32'h0));
    tbl2.push_back(mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, NOP_INST,     32'h0));
    tbl2.push_back(mk(1, 0, 0, 32'h0,        1, 32'h0,         1, 32'h3FFF_FFFF, 32'hFFFF_FFF8));
    tbl2.push_back(mk(1, 0, 0, 32'h0,        1, 32'h4,         1, 32'h4000_0000, 32'hFFFF_FFFC));
    tbl2.push_back(mk(1, 0, 0, 32'h0,        1, 32'h8,         1, 32'h1,        32'h0));

    run(tbl1, 1'b0, "main");
    run(tbl2, 1'b1, "wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
